// File: rtl/digit_counter.sv
// Debounced up/down digit counter feeding the 7-segment decoder.
// Two raw buttons are synchronized, debounced and edge-detected into single steps.
module digit_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MAX_VAL         = 8,
  parameter int unsigned WRAP            = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       clr,
  output logic [3:0] num,
  output logic       tick,
  output logic       at_max,
  output logic       at_min
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MAX_NUM = 4'(MAX_VAL);

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] stable;
  logic [1:0] stable_d;
  logic [1:0] step;
  logic [3:0] num_next;

  assign raw = {btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 2'b00;
      s2       <= 2'b00;
      stable_d <= 2'b00;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
    end
  end

  // A level is accepted only after it differs from stable for DEBOUNCE_CYCLES edges in a row.
  for (genvar g = 0; g < 2; g++) begin : g_debounce
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt       <= '0;
        stable[g] <= 1'b0;
      end else if (s2[g] == stable[g]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        stable[g] <= s2[g];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign step = stable & ~stable_d;

  always_comb begin
    num_next = num;
    if (clr) begin
      num_next = 4'd0;
    end else if (step[0] && step[1]) begin
      num_next = num;
    end else if (step[0]) begin
      if (num < MAX_NUM)     num_next = num + 4'd1;
      else if (WRAP != 0)    num_next = 4'd0;
    end else if (step[1]) begin
      if (num > 4'd0)        num_next = num - 4'd1;
      else if (WRAP != 0)    num_next = MAX_NUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num  <= 4'd0;
      tick <= 1'b0;
    end else begin
      num  <= num_next;
      tick <= (num_next != num);
    end
  end

  assign at_max = (num == MAX_NUM);
  assign at_min = (num == 4'd0);

endmodule

// File: tb/tb_digit_counter.sv
// Directed bench for digit_counter: a wrapping instance and a saturating instance
// share all inputs; each scenario task checks its own expected values.
module tb_digit_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       clr;
  logic [3:0] num0, num1;
  logic       tick0, tick1, at_max0, at_max1, at_min0, at_min1;

  int checks   = 0;
  int failures = 0;

  digit_counter #(.DEBOUNCE_CYCLES(4), .MAX_VAL(8), .WRAP(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .clr(clr),
    .num(num0), .tick(tick0), .at_max(at_max0), .at_min(at_min0)
  );

  digit_counter #(.DEBOUNCE_CYCLES(4), .MAX_VAL(8), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .clr(clr),
    .num(num1), .tick(tick1), .at_max(at_max1), .at_min(at_min1)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_clk();
    step_clk();
    rst_n = 1'b1;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    repeat (10) step_clk();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (10) step_clk();
  endtask

  task automatic test_reset();
    btn_up = 1'b0; btn_down = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (num0 !== 4'd0 || tick0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: num=%0d tick=%b, want num=0 tick=0", num0, tick0);
    end
    checks++;
    if (at_min0 !== 1'b1 || at_max0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: at_min=%b at_max=%b, want 1 0", at_min0, at_max0);
    end
    step_clk();
    rst_n = 1'b1;
  endtask

  task automatic test_hold_latency();
    logic [3:0] exp_num;
    do_reset();
    btn_up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step_clk();
      exp_num = (k >= 7) ? 4'd1 : 4'd0;
      checks++;
      if (num0 !== exp_num || tick0 !== (k == 7)) begin
        failures++;
        $display("FAIL hold_latency edge %0d: num=%0d tick=%b, want num=%0d tick=%b",
                 k, num0, tick0, exp_num, (k == 7));
      end
    end
    btn_up = 1'b0;
    repeat (10) step_clk();
    checks++;
    if (num0 !== 4'd1) begin
      failures++;
      $display("FAIL hold_release: num=%0d, want 1", num0);
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_num;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      press(1'b1, 1'b0);
      exp_num = 4'(i % 9);
      checks++;
      if (num0 !== exp_num || at_max0 !== (exp_num == 4'd8) || at_min0 !== (exp_num == 4'd0)) begin
        failures++;
        $display("FAIL wrap_up press %0d: num=%0d at_max=%b at_min=%b, want num=%0d at_max=%b at_min=%b",
                 i, num0, at_max0, at_min0, exp_num, (exp_num == 4'd8), (exp_num == 4'd0));
      end
    end
  endtask

  task automatic test_down_limits();
    int t0 = 0;
    int t1 = 0;
    do_reset();
    btn_down = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) btn_down = 1'b0;
      step_clk();
      if (tick0) t0++;
      if (tick1) t1++;
    end
    checks++;
    if (num0 !== 4'd8 || at_max0 !== 1'b1 || t0 != 1) begin
      failures++;
      $display("FAIL down_wrap: num=%0d at_max=%b ticks=%0d, want 8 1 1", num0, at_max0, t0);
    end
    checks++;
    if (num1 !== 4'd0 || t1 != 0) begin
      failures++;
      $display("FAIL down_saturate: num=%0d ticks=%0d, want 0 0", num1, t1);
    end
  endtask

  task automatic test_glitch();
    int t0 = 0;
    for (int r = 0; r < 8; r++) begin
      btn_up = 1'b1;
      repeat (3) begin step_clk(); if (tick0) t0++; end
      btn_up = 1'b0;
      repeat (3) begin step_clk(); if (tick0) t0++; end
    end
    repeat (10) begin step_clk(); if (tick0) t0++; end
    checks++;
    if (num0 !== 4'd8 || t0 != 0) begin
      failures++;
      $display("FAIL glitch_reject: num=%0d ticks=%0d, want 8 0", num0, t0);
    end
  endtask

  task automatic test_both_and_clr();
    int t0 = 0;
    do_reset();
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (15) begin step_clk(); if (tick0) t0++; end
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) begin step_clk(); if (tick0) t0++; end
    checks++;
    if (num0 !== 4'd0 || t0 != 0) begin
      failures++;
      $display("FAIL both_buttons: num=%0d ticks=%0d, want 0 0", num0, t0);
    end
    repeat (5) press(1'b1, 1'b0);
    checks++;
    if (num0 !== 4'd5) begin
      failures++;
      $display("FAIL setup_five: num=%0d, want 5", num0);
    end
    btn_up = 1'b1;
    repeat (6) step_clk();
    clr = 1'b1;
    step_clk();
    checks++;
    if (num0 !== 4'd0 || tick0 !== 1'b1) begin
      failures++;
      $display("FAIL clr_over_step: num=%0d tick=%b, want 0 1", num0, tick0);
    end
    clr = 1'b0;
    t0 = 0;
    repeat (14) begin step_clk(); if (tick0) t0++; end
    btn_up = 1'b0;
    repeat (10) begin step_clk(); if (tick0) t0++; end
    checks++;
    if (num0 !== 4'd0 || t0 != 0) begin
      failures++;
      $display("FAIL clr_discards_step: num=%0d ticks=%0d, want 0 0", num0, t0);
    end
  endtask

  task automatic test_reset_mid_press();
    logic [3:0] exp_num;
    do_reset();
    press(1'b1, 1'b0);
    checks++;
    if (num0 !== 4'd1) begin
      failures++;
      $display("FAIL midrst_setup: num=%0d, want 1", num0);
    end
    btn_up = 1'b1;
    repeat (4) step_clk();
    rst_n = 1'b0;
    #1;
    checks++;
    if (num0 !== 4'd0 || tick0 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_immediate: num=%0d tick=%b, want 0 0", num0, tick0);
    end
    step_clk();
    step_clk();
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step_clk();
      exp_num = (k >= 7) ? 4'd1 : 4'd0;
      checks++;
      if (num0 !== exp_num || tick0 !== (k == 7)) begin
        failures++;
        $display("FAIL midrst_relatch edge %0d: num=%0d tick=%b, want num=%0d tick=%b",
                 k, num0, tick0, exp_num, (k == 7));
      end
    end
    btn_up = 1'b0;
    repeat (5) step_clk();
  endtask

  initial begin
    test_reset();
    test_hold_latency();
    test_wrap_up();
    test_down_limits();
    test_glitch();
    test_both_and_clr();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
